// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit accumulator CPU control path.
// Opcode and sequencer state encodings live here.
package cpu_pkg;

    localparam int WORD_W   = 8;
    localparam int OP_W_DEF = 3;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'd0,
        OP_STORE = 3'd1,
        OP_ADD   = 3'd2,
        OP_SUB   = 3'd3,
        OP_BNE   = 3'd4,
        OP_IN    = 3'd5,
        OP_OUT   = 3'd6,
        OP_HALT  = 3'd7
    } opcode_t;

    typedef enum logic [3:0] {
        S_FETCH0,
        S_FETCH1,
        S_FETCH2,
        S_DECODE,
        S_EXEC1,
        S_EXEC2,
        S_BRANCH,
        S_INPUT,
        S_OUTPUT,
        S_HALT,
        S_ERROR
    } state_t;

endpackage

// File: rtl/seq_watchdog.sv
// Memory wait watchdog: counts stalled cycles of one access.
// expire fires when the access is still stalled at WAIT_MAX.
module seq_watchdog #(
    parameter int WAIT_MAX = 15
) (
    input  logic clock,
    input  logic n_reset,
    input  logic active,
    input  logic mem_ready,
    output logic expire
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    logic [CW-1:0] wait_cnt;

    // Idle between accesses keeps the count cleared for the next entry.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            wait_cnt <= '0;
        end else if (!active) begin
            wait_cnt <= '0;
        end else if (!mem_ready) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    assign expire = active && !mem_ready
                    && (wait_cnt == CW'(WAIT_MAX));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the accumulator CPU.
// Strobes are decoded from the registered state, gated off until the first edge after reset.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int OP_W     = OP_W_DEF,
    parameter int WAIT_MAX = 15
) (
    input  logic            clock,
    input  logic            n_reset,
    input  logic [OP_W-1:0] op,
    input  logic            z_flag,
    input  logic            mem_ready,
    output logic            ACC_bus,
    output logic            load_ACC,
    output logic            PC_bus,
    output logic            load_PC,
    output logic            INC_PC,
    output logic            load_IR,
    output logic            Addr_bus,
    output logic            load_MAR,
    output logic            MDR_bus,
    output logic            load_MDR,
    output logic            ALU_ACC,
    output logic            ALU_add,
    output logic            ALU_sub,
    output logic            CS,
    output logic            R_NW,
    output logic            sw_bus,
    output logic            load_disp,
    output logic            halted,
    output logic            bus_error
);

    state_t  state, state_nx;
    logic    run;
    logic    in_mem;
    logic    expire;
    logic    known;
    opcode_t opc;

    assign opc    = opcode_t'(op[2:0]);
    assign known  = ((op >> 3) == '0);
    assign in_mem = run && (state == S_FETCH1 || state == S_EXEC1);

    seq_watchdog #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wdog (
        .clock     (clock),
        .n_reset   (n_reset),
        .active    (in_mem),
        .mem_ready (mem_ready),
        .expire    (expire)
    );

    // run holds the strobes at reset values until the first edge after release.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state <= S_FETCH0;
            run   <= 1'b0;
        end else begin
            state <= state_nx;
            run   <= 1'b1;
        end
    end

    always_comb begin
        state_nx  = state;
        ACC_bus   = 1'b0;
        load_ACC  = 1'b0;
        PC_bus    = 1'b0;
        load_PC   = 1'b0;
        INC_PC    = 1'b0;
        load_IR   = 1'b0;
        Addr_bus  = 1'b0;
        load_MAR  = 1'b0;
        MDR_bus   = 1'b0;
        load_MDR  = 1'b0;
        ALU_add   = 1'b0;
        ALU_sub   = 1'b0;
        CS        = 1'b0;
        R_NW      = 1'b1;
        sw_bus    = 1'b0;
        load_disp = 1'b0;
        halted    = 1'b0;
        bus_error = 1'b0;
        if (run) begin
            unique case (state)
                S_FETCH0: begin
                    PC_bus   = 1'b1;
                    load_MAR = 1'b1;
                    INC_PC   = 1'b1;
                    state_nx = S_FETCH1;
                end
                S_FETCH1: begin
                    CS       = 1'b1;
                    load_MDR = mem_ready;
                    if (mem_ready)   state_nx = S_FETCH2;
                    else if (expire) state_nx = S_ERROR;
                end
                S_FETCH2: begin
                    MDR_bus  = 1'b1;
                    load_IR  = 1'b1;
                    state_nx = S_DECODE;
                end
                S_DECODE: begin
                    Addr_bus = 1'b1;
                    load_MAR = 1'b1;
                    if (!known) begin
                        state_nx = S_HALT;
                    end else begin
                        unique case (opc)
                            OP_LOAD, OP_STORE,
                            OP_ADD, OP_SUB: state_nx = S_EXEC1;
                            OP_BNE:         state_nx = S_BRANCH;
                            OP_IN:          state_nx = S_INPUT;
                            OP_OUT:         state_nx = S_OUTPUT;
                            default:        state_nx = S_HALT;
                        endcase
                    end
                end
                S_EXEC1: begin
                    CS = 1'b1;
                    if (opc == OP_STORE) begin
                        ACC_bus = 1'b1;
                        R_NW    = 1'b0;
                    end else begin
                        load_MDR = mem_ready;
                    end
                    if (mem_ready) begin
                        state_nx = (opc == OP_STORE) ? S_FETCH0 : S_EXEC2;
                    end else if (expire) begin
                        state_nx = S_ERROR;
                    end
                end
                S_EXEC2: begin
                    MDR_bus  = 1'b1;
                    load_ACC = 1'b1;
                    ALU_add  = (opc == OP_ADD);
                    ALU_sub  = (opc == OP_SUB);
                    state_nx = S_FETCH0;
                end
                S_BRANCH: begin
                    Addr_bus = !z_flag;
                    load_PC  = !z_flag;
                    state_nx = S_FETCH0;
                end
                S_INPUT: begin
                    sw_bus   = 1'b1;
                    load_ACC = 1'b1;
                    state_nx = S_FETCH0;
                end
                S_OUTPUT: begin
                    ACC_bus   = 1'b1;
                    load_disp = 1'b1;
                    state_nx  = S_FETCH0;
                end
                S_HALT:  halted    = 1'b1;
                S_ERROR: bus_error = 1'b1;
                default: state_nx  = S_FETCH0;
            endcase
        end
        ALU_ACC = load_ACC;
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench: instruction-level model expands each instruction into per-cycle strobe sets.
// A negedge monitor pops and compares one expected strobe set per cycle.
module tb_cpu_sequencer;

    logic       clock;
    logic       n_reset;
    logic [2:0] op;
    logic       z_flag;
    logic       mem_ready;
    logic ACC_bus, load_ACC, PC_bus, load_PC, INC_PC, load_IR;
    logic Addr_bus, load_MAR, MDR_bus, load_MDR, ALU_ACC, ALU_add, ALU_sub;
    logic CS, R_NW, sw_bus, load_disp, halted, bus_error;

    localparam logic [18:0] ACCB  = 19'h1 << 18;
    localparam logic [18:0] LACC  = 19'h1 << 17;
    localparam logic [18:0] PCB   = 19'h1 << 16;
    localparam logic [18:0] LPC   = 19'h1 << 15;
    localparam logic [18:0] INCPC = 19'h1 << 14;
    localparam logic [18:0] LIR   = 19'h1 << 13;
    localparam logic [18:0] ADRB  = 19'h1 << 12;
    localparam logic [18:0] LMAR  = 19'h1 << 11;
    localparam logic [18:0] MDRB  = 19'h1 << 10;
    localparam logic [18:0] LMDR  = 19'h1 << 9;
    localparam logic [18:0] AACC  = 19'h1 << 8;
    localparam logic [18:0] AADD  = 19'h1 << 7;
    localparam logic [18:0] ASUB  = 19'h1 << 6;
    localparam logic [18:0] CSB   = 19'h1 << 5;
    localparam logic [18:0] RNW   = 19'h1 << 4;
    localparam logic [18:0] SWB   = 19'h1 << 3;
    localparam logic [18:0] LDSP  = 19'h1 << 2;
    localparam logic [18:0] HLT   = 19'h1 << 1;
    localparam logic [18:0] BERR  = 19'h1;
    localparam logic [18:0] RSTV  = RNW;

    localparam int WMAX = 15;

    logic [18:0] dutv;
    assign dutv = {ACC_bus, load_ACC, PC_bus, load_PC, INC_PC, load_IR,
                   Addr_bus, load_MAR, MDR_bus, load_MDR, ALU_ACC,
                   ALU_add, ALU_sub, CS, R_NW, sw_bus, load_disp,
                   halted, bus_error};

    cpu_sequencer #(
        .OP_W     (3),
        .WAIT_MAX (WMAX)
    ) dut (
        .clock     (clock),
        .n_reset   (n_reset),
        .op        (op),
        .z_flag    (z_flag),
        .mem_ready (mem_ready),
        .ACC_bus   (ACC_bus),
        .load_ACC  (load_ACC),
        .PC_bus    (PC_bus),
        .load_PC   (load_PC),
        .INC_PC    (INC_PC),
        .load_IR   (load_IR),
        .Addr_bus  (Addr_bus),
        .load_MAR  (load_MAR),
        .MDR_bus   (MDR_bus),
        .load_MDR  (load_MDR),
        .ALU_ACC   (ALU_ACC),
        .ALU_add   (ALU_add),
        .ALU_sub   (ALU_sub),
        .CS        (CS),
        .R_NW      (R_NW),
        .sw_bus    (sw_bus),
        .load_disp (load_disp),
        .halted    (halted),
        .bus_error (bus_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [18:0] expq[$];
    int          total = 0;
    int          bad   = 0;
    int          cycn  = 0;
    bit          mon_en = 1'b0;

    always @(negedge clock) begin
        if (mon_en && n_reset) begin
            cycn++;
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL underflow cycle=%0d got=%h exp=none", cycn, dutv);
            end else begin
                logic [18:0] e;
                e = expq.pop_front();
                if (dutv !== e) begin
                    bad++;
                    $display("FAIL strobes cycle=%0d got=%h exp=%h", cycn, dutv, e);
                end
            end
        end
    end

    task automatic cyc(input logic [2:0] o, input logic rdy,
                       input logic z, input logic [18:0] e);
        @(posedge clock);
        #1;
        op        = o;
        mem_ready = rdy;
        z_flag    = z;
        expq.push_back(e);
    endtask

    // Memory access: w stalled cycles, then one completing cycle.
    task automatic mem_access(input logic [2:0] o, input int w,
                              input logic [18:0] stall, input logic [18:0] done);
        for (int i = 0; i < w; i++) cyc(o, 1'b0, 1'($urandom), stall);
        cyc(o, 1'b1, 1'($urandom), done);
    endtask

    task automatic instr(input logic [2:0] o, input int wf, input int we);
        logic z;
        cyc(o, 1'($urandom), 1'($urandom), PCB | LMAR | INCPC | RNW);
        mem_access(o, wf, CSB | RNW, CSB | RNW | LMDR);
        cyc(o, 1'($urandom), 1'($urandom), MDRB | LIR | RNW);
        cyc(o, 1'($urandom), 1'($urandom), ADRB | LMAR | RNW);
        case (o)
            3'd0, 3'd2, 3'd3: begin
                mem_access(o, we, CSB | RNW, CSB | RNW | LMDR);
                cyc(o, 1'($urandom), 1'($urandom),
                    MDRB | LACC | AACC | RNW
                    | ((o == 3'd2) ? AADD : 19'h0)
                    | ((o == 3'd3) ? ASUB : 19'h0));
            end
            3'd1: mem_access(o, we, ACCB | CSB, ACCB | CSB);
            3'd4: begin
                z = 1'($urandom);
                cyc(o, 1'($urandom), z, RNW | (z ? 19'h0 : (ADRB | LPC)));
            end
            3'd5: cyc(o, 1'($urandom), 1'($urandom), SWB | LACC | AACC | RNW);
            3'd6: cyc(o, 1'($urandom), 1'($urandom), ACCB | LDSP | RNW);
            default: ;
        endcase
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clock);
        #1;
        mon_en  = 1'b0;
        n_reset = 1'b0;
        #1;
        total++;
        if (dutv !== RSTV) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, dutv, RSTV);
        end
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL %s_pending got=%0d exp=0", tag, expq.size());
        end
        expq.delete();
        #1;
        n_reset = 1'b1;
        mon_en  = 1'b1;
    endtask

    initial begin
        n_reset   = 1'b1;
        op        = 3'd0;
        z_flag    = 1'b0;
        mem_ready = 1'b1;
        #1 n_reset = 1'b0;
        #1;
        total++;
        if (dutv !== RSTV) begin
            bad++;
            $display("FAIL reset got=%h exp=%h", dutv, RSTV);
        end
        #1 n_reset = 1'b1;
        mon_en = 1'b1;

        instr(3'd0, 0, 0);
        instr(3'd2, 0, 0);
        instr(3'd3, 0, 0);
        instr(3'd1, 0, 0);
        instr(3'd4, 0, 0);
        instr(3'd5, 0, 0);
        instr(3'd6, 0, 0);
        instr(3'd0, 3, 0);
        instr(3'd1, 0, 2);
        instr(3'd2, WMAX, WMAX);
        for (int n = 0; n < 40; n++) begin
            int wf, we;
            wf = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
            we = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
            instr(3'($urandom_range(0, 6)), wf, we);
        end

        // Reset in the middle of a stalled fetch.
        cyc(3'd0, 1'b0, 1'b0, PCB | LMAR | INCPC | RNW);
        cyc(3'd0, 1'b0, 1'b0, CSB | RNW);
        cyc(3'd0, 1'b0, 1'b0, CSB | RNW);
        pulse_reset("reset_mid");

        // Hung fetch: WMAX+1 stalled cycles, then sticky error.
        cyc(3'd0, 1'b0, 1'b0, PCB | LMAR | INCPC | RNW);
        for (int i = 0; i < WMAX + 1; i++) cyc(3'd0, 1'b0, 1'b0, CSB | RNW);
        for (int i = 0; i < 6; i++) cyc(3'd0, 1'($urandom), 1'b0, BERR | RNW);
        pulse_reset("reset_err");

        // Hung store data phase.
        instr(3'd1, 0, 0);
        cyc(3'd1, 1'b1, 1'b0, PCB | LMAR | INCPC | RNW);
        cyc(3'd1, 1'b1, 1'b0, CSB | RNW | LMDR);
        cyc(3'd1, 1'b0, 1'b0, MDRB | LIR | RNW);
        cyc(3'd1, 1'b0, 1'b0, ADRB | LMAR | RNW);
        for (int i = 0; i < WMAX + 1; i++) cyc(3'd1, 1'b0, 1'b0, ACCB | CSB);
        cyc(3'd1, 1'b1, 1'b0, BERR | RNW);
        pulse_reset("reset_err2");

        instr(3'd7, 0, 0);
        for (int i = 0; i < 100; i++) cyc(3'd7, 1'($urandom), 1'($urandom), HLT | RNW);

        @(negedge clock);
        #1;
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d exp=0", expq.size());
        end
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
